// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- signal bundle between state_control/datapath and fetch_unit.
//   state          : current processor state (IF=0 .. OUTPUT=6, 7 illegal)
//   prog_we/addr/data : instruction-memory write port
//   branch_taken/target : branch resolution, used only in WB
//   program_counter, instr, instr_valid, retired_count, done : fetch outputs
// master drives the control/program inputs; slave is the fetch unit itself.
interface fetch_unit_if;
  logic [2:0]  state;
  logic        prog_we;
  logic [2:0]  prog_addr;
  logic [15:0] prog_data;
  logic        branch_taken;
  logic [2:0]  branch_target;
  logic [2:0]  program_counter;
  logic [15:0] instr;
  logic        instr_valid;
  logic [3:0]  retired_count;
  logic        done;

  modport master (
    output state, prog_we, prog_addr, prog_data, branch_taken, branch_target,
    input  program_counter, instr, instr_valid, retired_count, done
  );

  modport slave (
    input  state, prog_we, prog_addr, prog_data, branch_taken, branch_target,
    output program_counter, instr, instr_valid, retired_count, done
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- 8-entry instruction memory, program counter and instruction
// register, advanced by the processor state supplied from state_control.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (imem is not reset)
//   bus   : fetch_unit_if.slave (state, program port, branch inputs; PC,
//           instr, instr_valid, retired_count, done outputs)
// All outputs come straight from registers.
module fetch_unit (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IF      = 3'd0,
    ST_ID      = 3'd1,
    ST_RR      = 3'd2,
    ST_EX      = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_OUTPUT  = 3'd6,
    ST_ILLEGAL = 3'd7
  } state_e;

  state_e      w_state;
  logic [15:0] r_imem [8];

  logic [2:0]  r_pc,      w_pc_nxt;
  logic [15:0] r_instr,   w_instr_nxt;
  logic        r_valid,   w_valid_nxt;
  logic [3:0]  r_retired, w_retired_nxt;
  logic        r_done,    w_done_nxt;

  assign w_state = state_e'(bus.state);

  // No reset: program contents survive rst_n. Non-blocking write gives
  // read-before-write against a same-edge IF capture.
  always_ff @(posedge clk) begin
    if (bus.prog_we) r_imem[bus.prog_addr] <= bus.prog_data;
  end

  always_comb begin
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_valid_nxt   = r_valid;
    w_retired_nxt = r_retired;
    w_done_nxt    = r_done;
    case (w_state)
      ST_IF: begin
        w_instr_nxt = r_imem[r_pc];
        w_valid_nxt = 1'b1;
      end
      ST_WB: begin
        // PC 7 is the last slot: hold it, state_control moves to OUTPUT.
        if (r_pc != 3'd7)
          w_pc_nxt = bus.branch_taken ? bus.branch_target : r_pc + 3'd1;
        w_valid_nxt = 1'b0;
        if (r_retired != 4'hF) w_retired_nxt = r_retired + 4'd1;
      end
      ST_OUTPUT: w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_retired <= '0;
      r_done    <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_valid   <= w_valid_nxt;
      r_retired <= w_retired_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.program_counter = r_pc;
  assign bus.instr           = r_instr;
  assign bus.instr_valid     = r_valid;
  assign bus.retired_count   = r_retired;
  assign bus.done            = r_done;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state updated once per clock edge.
  logic [15:0] m_mem [8];
  logic [2:0]  m_pc;
  logic [15:0] m_instr;
  logic        m_valid;
  logic [3:0]  m_ret;
  logic        m_done;

  typedef struct {
    logic [2:0]  st;
    logic [2:0]  pc;
    logic [15:0] instr;
    logic        valid;
    logic [3:0]  ret;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_pc"},    16'(bus.program_counter), 16'(m_pc));
    chk({tag, "_instr"}, bus.instr,                m_instr);
    chk({tag, "_valid"}, 16'(bus.instr_valid),     16'(m_valid));
    chk({tag, "_ret"},   16'(bus.retired_count),   16'(m_ret));
    chk({tag, "_done"},  16'(bus.done),            16'(m_done));
  endtask

  task automatic model_reset();
    m_pc = '0; m_instr = '0; m_valid = 1'b0; m_ret = '0; m_done = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] st, input logic we, input logic [2:0] addr,
                            input logic [15:0] data, input logic bt, input logic [2:0] tgt);
    if (st == 3'd0) begin
      m_instr = m_mem[m_pc];
      m_valid = 1'b1;
    end else if (st == 3'd5) begin
      if (m_pc < 3'd7) m_pc = bt ? tgt : 3'(m_pc + 1);
      m_valid = 1'b0;
      if (m_ret < 4'd15) m_ret = 4'(m_ret + 1);
    end else if (st == 3'd6) begin
      m_done = 1'b1;
    end
    if (we) m_mem[addr] = data;  // after the read: old word is captured
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic [2:0] st, input logic we, input logic [2:0] addr,
                      input logic [15:0] data, input logic bt, input logic [2:0] tgt,
                      input string tag);
    bus.state = st; bus.prog_we = we; bus.prog_addr = addr; bus.prog_data = data;
    bus.branch_taken = bt; bus.branch_target = tgt;
    @(posedge clk);
    model_edge(st, we, addr, data, bt, tgt);
    #1;
    chk_model(tag);
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  // Reset asserted between edges; outputs checked before any clock edge.
  task automatic rst_mid();
    bus.prog_we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc",    16'(bus.program_counter), 16'h0);
    chk("rst_instr", bus.instr,                16'h0);
    chk("rst_valid", 16'(bus.instr_valid),     16'h0);
    chk("rst_ret",   16'(bus.retired_count),   16'h0);
    chk("rst_done",  16'(bus.done),            16'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic bt, input logic [2:0] tgt);
    for (int s = 0; s < 6; s++) step(3'(s), 1'b0, 3'd0, 16'h0, bt, tgt, "seq");
  endtask

  initial begin
    vec_t v;
    bus.state = 3'd1; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.branch_taken = 1'b0; bus.branch_target = '0;

    // Straight-line program: expected results per edge derived by hand.
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < 6; s++) begin
        v.st    = 3'(s);
        v.pc    = (s == 5) ? ((i == 7) ? 3'd7 : 3'(i + 1)) : 3'(i);
        v.instr = 16'(16'h1000 + i);
        v.valid = (s != 5);
        v.ret   = (s == 5) ? 4'(i + 1) : 4'(i);
        v.done  = 1'b0;
        tbl.push_back(v);
      end
    end
    v.st = 3'd6; v.pc = 3'd7; v.instr = 16'h1007; v.valid = 1'b0; v.ret = 4'd8; v.done = 1'b1;
    tbl.push_back(v);
    v.st = 3'd0; v.valid = 1'b1;  // refetch after OUTPUT: done stays set
    tbl.push_back(v);

    rst_mid();
    for (int a = 0; a < 8; a++) step(3'd1, 1'b1, 3'(a), 16'(16'h1000 + a), 1'b0, 3'd0, "load");

    foreach (tbl[k]) begin
      step(tbl[k].st, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, "tblm");
      chk("tbl_pc",    16'(bus.program_counter), 16'(tbl[k].pc));
      chk("tbl_instr", bus.instr,                tbl[k].instr);
      chk("tbl_valid", 16'(bus.instr_valid),     16'(tbl[k].valid));
      chk("tbl_ret",   16'(bus.retired_count),   16'(tbl[k].ret));
      chk("tbl_done",  16'(bus.done),            16'(tbl[k].done));
    end

    // Forward branch 3 -> 6.
    rst_mid();
    run_instr(1'b0, 3'd0); run_instr(1'b0, 3'd0); run_instr(1'b0, 3'd0);
    run_instr(1'b1, 3'd6);
    chk("br_pc", 16'(bus.program_counter), 16'h6);
    step(3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, "br_if");
    chk("br_instr", bus.instr, 16'h1006);
    for (int s = 1; s < 6; s++) step(3'(s), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, "br");
    run_instr(1'b0, 3'd0);
    step(3'd6, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, "br_out");
    chk("br_ret",  16'(bus.retired_count), 16'd6);
    chk("br_done", 16'(bus.done),          16'd1);

    // Async reset during EX at PC 5.
    rst_mid();
    for (int n = 0; n < 5; n++) run_instr(1'b0, 3'd0);
    for (int s = 0; s < 4; s++) step(3'(s), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, "ex5");
    chk("ex5_pc", 16'(bus.program_counter), 16'h5);
    rst_mid();

    // Read-before-write at PC 0 (also shows imem[0] survived reset).
    step(3'd0, 1'b1, 3'd0, 16'hBEEF, 1'b0, 3'd0, "rbw");
    chk("rbw_old", bus.instr, 16'h1000);
    for (int s = 1; s < 6; s++) step(3'(s), 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, "rbw");
    step(3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, "rbw2");
    chk("rbw_new", bus.instr, 16'hBEEF);

    // Backward loop 2 -> 0, six times: 18 retirements saturate at 15.
    rst_mid();
    for (int n = 0; n < 6; n++) begin
      run_instr(1'b0, 3'd0); run_instr(1'b0, 3'd0); run_instr(1'b1, 3'd0);
    end
    chk("sat_ret", 16'(bus.retired_count), 16'd15);

    // Illegal state 7 for 3 cycles with a branch offered.
    step(3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, "ill_if");
    for (int n = 0; n < 3; n++) step(3'd7, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, "ill");
    chk("ill_pc",    16'(bus.program_counter), 16'h0);
    chk("ill_instr", bus.instr,                16'hBEEF);
    chk("ill_valid", 16'(bus.instr_valid),     16'h1);
    chk("ill_ret",   16'(bus.retired_count),   16'd15);
    chk("ill_done",  16'(bus.done),            16'h0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) rst_mid();
      else step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
